// File: rtl/chacha_ks_sched_pkg.sv
// Shared types and constants for the ChaCha keystream scheduler.
package chacha_ks_sched_pkg;

  typedef logic [31:0] word_t;

  // "expand 32-byte k" as four little-endian words.
  localparam word_t [0:3] CHACHA_CONST = {
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  // Index of the final byte within a 64-byte block.
  localparam logic [5:0] LAST_BYTE = 6'd63;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BF,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/chacha_block_unpacker.sv
// Holds one 16-word block-function result and serialises it into bytes,
// little-endian within each word.
module chacha_block_unpacker
  import chacha_ks_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  word_t [0:15]      block,
  input  logic  [5:0]       byte_idx,
  output logic  [7:0]       byte_out
);

  word_t [0:15] hold;
  word_t        sel_word;

  // Capture the core's output state when the scheduler accepts a block.
  // NOTE: this wide register is still reset, so a reset mid-job leaves no trace of the old keystream.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      hold <= '0;
    end else if (load) begin
      hold <= block;
    end
  end

  // Byte k comes from word k/4, lane k%4, least significant lane first.
  always_comb begin
    // NOTE: defaults first in combinational blocks so no path leaves a signal unassigned (no latch).
    sel_word = hold[byte_idx[5:2]];
    byte_out = sel_word[{byte_idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/chacha_ks_sched.sv
// ChaCha20 keystream scheduler: launches the block-function core once per
// 64-byte block, advances the block counter and streams the result out
// through a valid/ready byte interface.
module chacha_ks_sched
  import chacha_ks_sched_pkg::*;
#(
  parameter int unsigned MAX_BLOCKS = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  word_t [0:7]       key,
  input  word_t [0:2]       nonce,
  input  logic  [31:0]      counter_init,
  input  logic  [15:0]      num_blocks,
  output logic              bf_start,
  output word_t [0:3]       bf_constant,
  output word_t [0:7]       bf_key,
  output word_t [0:2]       bf_nonce,
  output logic  [31:0]      bf_counter,
  input  logic              bf_done,
  input  word_t [0:15]      bf_block,
  output logic  [7:0]       ks_byte,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              ks_last,
  output logic              busy,
  output logic              done,
  output logic              err_wrap
);

  state_t      state;
  logic [5:0]  byte_idx;
  logic [15:0] remaining;
  logic [31:0] counter_next;
  logic        load;

  assign bf_constant  = CHACHA_CONST;
  assign counter_next = bf_counter + 32'd1;
  // Abort wins over a block arriving in the same cycle.
  assign load         = (state == WAIT_BF) && bf_done && !abort;

  chacha_block_unpacker u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .block    (bf_block),
    .byte_idx (byte_idx),
    .byte_out (ks_byte)
  );

  // Job sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bf_start   <= 1'b0;
      ks_valid   <= 1'b0;
      ks_last    <= 1'b0;
      err_wrap   <= 1'b0;
      byte_idx   <= '0;
      remaining  <= '0;
      bf_counter <= '0;
      bf_key     <= '0;
      bf_nonce   <= '0;
    end else begin
      done     <= 1'b0;
      bf_start <= 1'b0;
      if (abort && (state != IDLE)) begin
        state    <= IDLE;
        busy     <= 1'b0;
        ks_valid <= 1'b0;
        ks_last  <= 1'b0;
        byte_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (num_blocks == 16'd0) begin
                // Empty job: acknowledge immediately without touching the core.
                done     <= 1'b1;
                err_wrap <= 1'b0;
              end else if ({16'd0, num_blocks} <= MAX_BLOCKS) begin
                bf_key     <= key;
                bf_nonce   <= nonce;
                bf_counter <= counter_init;
                remaining  <= num_blocks;
                err_wrap   <= 1'b0;
                busy       <= 1'b1;
                bf_start   <= 1'b1;
                state      <= LAUNCH;
              end
            end
          end
          LAUNCH: begin
            state <= WAIT_BF;
          end
          WAIT_BF: begin
            if (bf_done) begin
              state    <= DRAIN;
              ks_valid <= 1'b1;
              ks_last  <= 1'b0;
              byte_idx <= '0;
            end
          end
          DRAIN: begin
            if (ks_ready) begin
              if (byte_idx == LAST_BYTE) begin
                remaining  <= remaining - 16'd1;
                bf_counter <= counter_next;
                ks_valid   <= 1'b0;
                ks_last    <= 1'b0;
                byte_idx   <= '0;
                if (remaining == 16'd1) begin
                  state <= FINISH;
                  done  <= 1'b1;
                end else if (counter_next == 32'd0) begin
                  // Counter would repeat keystream: stop instead of launching.
                  state    <= FINISH;
                  done     <= 1'b1;
                  err_wrap <= 1'b1;
                end else begin
                  state    <= LAUNCH;
                  bf_start <= 1'b1;
                end
              end else begin
                byte_idx <= byte_idx + 6'd1;
                ks_last  <= (byte_idx == (LAST_BYTE - 6'd1)) && (remaining == 16'd1);
              end
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_ks_sched.sv
// Randomised bench for chacha_ks_sched with a behavioural ChaCha20 core and
// a scoreboard that derives the expected keystream from the job parameters.
module tb_chacha_ks_sched;
  import chacha_ks_sched_pkg::*;

  typedef word_t [0:15] blk_t;
  typedef word_t [0:7]  key_t;
  typedef word_t [0:2]  nonce_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  key_t        key = '0;
  nonce_t      nonce = '0;
  word_t       counter_init = '0;
  logic [15:0] num_blocks = '0;
  logic        bf_start;
  word_t [0:3] bf_constant;
  key_t        bf_key;
  nonce_t      bf_nonce;
  word_t       bf_counter;
  logic        bf_done = 1'b0;
  blk_t        bf_block;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        ks_ready = 1'b1;
  logic        ks_last;
  logic        busy;
  logic        done;
  logic        err_wrap;

  chacha_ks_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .key          (key),
    .nonce        (nonce),
    .counter_init (counter_init),
    .num_blocks   (num_blocks),
    .bf_start     (bf_start),
    .bf_constant  (bf_constant),
    .bf_key       (bf_key),
    .bf_nonce     (bf_nonce),
    .bf_counter   (bf_counter),
    .bf_done      (bf_done),
    .bf_block     (bf_block),
    .ks_byte      (ks_byte),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .ks_last      (ks_last),
    .busy         (busy),
    .done         (done),
    .err_wrap     (err_wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- ChaCha20 reference ----------------
  function automatic word_t rotl(word_t v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic blk_t qr(blk_t v, int a, int b, int c, int d);
    v[a] = v[a] + v[b]; v[d] = rotl(v[d] ^ v[a], 16);
    v[c] = v[c] + v[d]; v[b] = rotl(v[b] ^ v[c], 12);
    v[a] = v[a] + v[b]; v[d] = rotl(v[d] ^ v[a], 8);
    v[c] = v[c] + v[d]; v[b] = rotl(v[b] ^ v[c], 7);
    return v;
  endfunction

  function automatic blk_t chacha_block(key_t k, nonce_t n, word_t c);
    blk_t s, x, o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[i];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[i];
    x = s;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) o[i] = x[i] + s[i];
    return o;
  endfunction

  // ---------------- job context / scoreboard ----------------
  key_t       job_key;
  nonce_t     job_nonce;
  word_t      job_ctr;
  word_t      launch_idx;
  int         ready_mode = 0;
  int         start_cyc, first_bf_cyc, done_cyc;
  int         n_bf, n_done, n_valid;
  logic [7:0] byte_q [$];
  bit         last_q [$];
  logic [7:0] exp_q [$];
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;
  logic [7:0] prev_byte = '0;

  task automatic reset_monitor();
    byte_q.delete(); last_q.delete(); exp_q.delete();
    n_bf = 0; n_done = 0; n_valid = 0;
    first_bf_cyc = -1; done_cyc = -1; launch_idx = '0;
  endtask

  task automatic build_exp(key_t k, nonce_t n, word_t c, int emit);
    blk_t b;
    exp_q.delete();
    for (int blk = 0; blk < emit; blk++) begin
      b = chacha_block(k, n, c + word_t'(blk));
      for (int i = 0; i < 64; i++) exp_q.push_back(b[i/4][8*(i%4) +: 8]);
    end
  endtask

  function automatic key_t rand_key();
    key_t k;
    for (int i = 0; i < 8; i++) k[i] = $urandom;
    return k;
  endfunction

  function automatic nonce_t rand_nonce();
    nonce_t n;
    for (int i = 0; i < 3; i++) n[i] = $urandom;
    return n;
  endfunction

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bf_start) begin
        if (n_bf == 0) first_bf_cyc = cyc;
        n_bf++;
      end
      if (done) begin
        if (n_done == 0) done_cyc = cyc;
        n_done++;
      end
      if (ks_valid) n_valid++;
      if (ks_valid && prev_valid && !prev_ready && !prev_abort)
        check("ks_stable", ks_byte, prev_byte);
      if (ks_valid && ks_ready && !abort) begin
        byte_q.push_back(ks_byte);
        last_q.push_back(ks_last);
      end
    end
    prev_valid = ks_valid; prev_ready = ks_ready;
    prev_byte  = ks_byte;  prev_abort = abort;
  end

  // Behavioural block-function core with random latency.
  initial begin
    blk_t blk;
    int   lat;
    bf_block = '0;
    forever begin
      @(negedge clk);
      if (bf_start && !rst) begin
        check("bf_counter", bf_counter, job_ctr + launch_idx);
        check("bf_key", bf_key, job_key);
        check("bf_nonce", bf_nonce, job_nonce);
        check("bf_constant", bf_constant,
              {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574});
        launch_idx = launch_idx + 32'd1;
        blk = chacha_block(bf_key, bf_nonce, bf_counter);
        lat = $urandom_range(1, 4);
        repeat (lat) @(posedge clk);
        #1 bf_done = 1'b1; bf_block = blk;
        @(posedge clk);
        #1 bf_done = 1'b0;
        for (int i = 0; i < 16; i++) bf_block[i] = $urandom;
      end
    end
  end

  // Consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1 ks_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_start(key_t k, nonce_t n, word_t c, logic [15:0] nb);
    @(posedge clk);
    #1 key = k; nonce = n; counter_init = c; num_blocks = nb; start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    key = rand_key(); nonce = rand_nonce(); counter_init = $urandom;
    num_blocks = 16'($urandom);
  endtask

  task automatic run_job(key_t k, nonce_t n, word_t c, logic [15:0] nb,
                         int mode, bit restart);
    logic [32:0] room;
    int          emit, nl, lim;
    bit          err;
    room = 33'h1_0000_0000 - {1'b0, c};
    if ({17'd0, nb} > room) begin emit = int'(room); err = 1'b1; end
    else begin emit = int'(nb); err = 1'b0; end
    reset_monitor();
    job_key = k; job_nonce = n; job_ctr = c;
    build_exp(k, n, c, emit);
    ready_mode = mode;
    drive_start(k, n, c, nb);
    if (nb != 16'd0) check("busy_on", busy, 1'b1);
    if (restart) begin
      repeat (30) @(posedge clk);
      #1 start = 1'b1; key = rand_key(); counter_init = $urandom; num_blocks = 16'd5;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int t = 0; t < 6000 && n_done == 0; t++) @(posedge clk);
    check("done_seen", n_done, 1);
    repeat (5) @(posedge clk);
    #1;
    check("done_count", n_done, 1);
    check("bf_start_count", n_bf, emit);
    check("err_wrap", err_wrap, err);
    check("busy_end", busy, 1'b0);
    check("byte_count", byte_q.size(), emit * 64);
    lim = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("ks_byte[%0d]", i), byte_q[i], exp_q[i]);
    if (nb == 16'd0) begin
      check("done_latency", done_cyc - start_cyc, 1);
      check("valid_cycles", n_valid, 0);
    end else begin
      check("bf_start_latency", first_bf_cyc - start_cyc, 1);
    end
    if (!err && emit > 0 && last_q.size() > 0) begin
      nl = 0;
      foreach (last_q[i]) if (last_q[i]) nl++;
      check("ks_last_count", nl, 1);
      check("ks_last_pos", last_q[last_q.size()-1], 1'b1);
    end
    ready_mode = 0;
  endtask

  logic [7:0] rfc_bytes [8] = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_t   k;
    nonce_t n;
    word_t  c;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bf_start", bf_start, 1'b0);
    check("rst_ks_valid", ks_valid, 1'b0);
    check("rst_ks_last", ks_last, 1'b0);
    check("rst_err_wrap", err_wrap, 1'b0);
    check("rst_ks_byte", ks_byte, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Known-answer block: key bytes 00..1f, counter 1.
    for (int i = 0; i < 8; i++)
      k[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    n = {32'h09000000, 32'h4a000000, 32'h00000000};
    run_job(k, n, 32'd1, 16'd1, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      if (i < byte_q.size()) check($sformatf("kat_byte[%0d]", i), byte_q[i], rfc_bytes[i]);

    // Three blocks from counter 5, with a start pulse while busy.
    run_job(rand_key(), rand_nonce(), 32'd5, 16'd3, 0, 1'b1);

    // Random back-pressure.
    run_job(rand_key(), rand_nonce(), $urandom, 16'd2, 1, 1'b0);

    // Counter wrap with blocks remaining.
    run_job(rand_key(), rand_nonce(), 32'hFFFF_FFFF, 16'd2, 0, 1'b0);

    // Empty job.
    run_job(rand_key(), rand_nonce(), $urandom, 16'd0, 0, 1'b0);

    // Abort at byte 20 of the second block.
    k = rand_key(); n = rand_nonce(); c = $urandom_range(0, 1000);
    reset_monitor();
    job_key = k; job_nonce = n; job_ctr = c;
    build_exp(k, n, c, 3);
    drive_start(k, n, c, 16'd3);
    for (int t = 0; t < 2000 && byte_q.size() < 84; t++) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_ks_valid", ks_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_byte_count", byte_q.size(), 84);
    for (int i = 0; i < byte_q.size() && i < exp_q.size(); i++)
      check($sformatf("abort_byte[%0d]", i), byte_q[i], exp_q[i]);

    // Normal job after abort.
    run_job(rand_key(), rand_nonce(), $urandom, 16'd1, 1, 1'b0);

    // Random jobs, the first one ending exactly at the counter wrap.
    for (int j = 0; j < 3; j++) begin
      if (j == 0) run_job(rand_key(), rand_nonce(), 32'hFFFF_FFFE, 16'd2, 1, 1'b0);
      else run_job(rand_key(), rand_nonce(), $urandom,
                   16'($urandom_range(1, 3)), $urandom_range(0, 1), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
